// File: rtl/add_rs_snoop.sv
// Adder reservation station that snoops the adder and multiplier CDBs for pending operands.
// Optional RS_AGE_ORDER_EN: issue the oldest ready entry instead of the lowest-index one.
module add_rs_snoop #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [2:0]                 disp_op,
    input  logic [TAG_W-1:0]           disp_dest_tag,
    input  logic [TAG_W-1:0]           disp_qj,
    input  logic [TAG_W-1:0]           disp_qk,
    input  logic [DATA_W-1:0]          disp_vj,
    input  logic [DATA_W-1:0]          disp_vk,
    input  logic [TAG_W-1:0]           add_broad_tag,
    input  logic [DATA_W-1:0]          add_broad_data,
    input  logic [TAG_W-1:0]           mul_broad_tag,
    input  logic [DATA_W-1:0]          mul_broad_data,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [2:0]                 iss_op,
    output logic [TAG_W-1:0]           iss_tag,
    output logic [DATA_W-1:0]          iss_a,
    output logic [DATA_W-1:0]          iss_b,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [2:0]        op_q   [DEPTH];
    logic [2:0]        op_d   [DEPTH];
    logic [TAG_W-1:0]  dest_q [DEPTH];
    logic [TAG_W-1:0]  dest_d [DEPTH];
    logic [TAG_W-1:0]  qj_q   [DEPTH];
    logic [TAG_W-1:0]  qj_d   [DEPTH];
    logic [TAG_W-1:0]  qk_q   [DEPTH];
    logic [TAG_W-1:0]  qk_d   [DEPTH];
    logic [DATA_W-1:0] vj_q   [DEPTH];
    logic [DATA_W-1:0] vj_d   [DEPTH];
    logic [DATA_W-1:0] vk_q   [DEPTH];
    logic [DATA_W-1:0] vk_d   [DEPTH];
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [DEPTH-1:0]  ready;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              disp_fire;
    logic              iss_fire;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = busy_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

`ifdef RS_AGE_ORDER_EN
    // older_q[i][j] set means entry i was dispatched before entry j.
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic             sel_found;
    logic             blocked;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        blocked   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && older_q[j][i]) blocked = 1'b1;
            end
            if (ready[i] && !blocked && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        older_d = older_q;
        if (disp_fire) begin
            older_d[free_idx] = '0;
            for (int i = 0; i < DEPTH; i++) older_d[i][free_idx] = busy_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else begin
            older_q <= older_d;
        end
    end
`else
    // A stalled offer stays locked so the FU sees stable iss_* until it accepts.
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             low_found;
    logic [IDX_W-1:0] low_idx;

    always_comb begin
        low_found = 1'b0;
        low_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !low_found) begin
                low_found = 1'b1;
                low_idx   = IDX_W'(i);
            end
        end
        sel_idx    = lock_q ? lock_idx_q : low_idx;
        lock_d     = iss_valid && !iss_ready;
        lock_idx_d = sel_idx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`endif

    assign disp_ready = free_found;
    assign iss_valid  = |ready;
    assign disp_fire  = disp_valid && free_found;
    assign iss_fire   = iss_valid && iss_ready;
    assign occupancy  = occ_q;

    always_comb begin
        iss_op  = '0;
        iss_tag = '0;
        iss_a   = '0;
        iss_b   = '0;
        if (iss_valid) begin
            iss_op  = op_q[sel_idx];
            iss_tag = dest_q[sel_idx];
            iss_a   = vj_q[sel_idx];
            iss_b   = vk_q[sel_idx];
        end
    end

    always_comb begin
        busy_d = busy_q;
        op_d   = op_q;
        dest_d = dest_q;
        qj_d   = qj_q;
        qk_d   = qk_q;
        vj_d   = vj_q;
        vk_d   = vk_q;
        occ_d  = occ_q;

        // Add CDB has priority when both buses carry the same tag.
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && qj_q[i] != '0) begin
                if (qj_q[i] == add_broad_tag) begin
                    qj_d[i] = '0;
                    vj_d[i] = add_broad_data;
                end else if (qj_q[i] == mul_broad_tag) begin
                    qj_d[i] = '0;
                    vj_d[i] = mul_broad_data;
                end
            end
            if (busy_q[i] && qk_q[i] != '0) begin
                if (qk_q[i] == add_broad_tag) begin
                    qk_d[i] = '0;
                    vk_d[i] = add_broad_data;
                end else if (qk_q[i] == mul_broad_tag) begin
                    qk_d[i] = '0;
                    vk_d[i] = mul_broad_data;
                end
            end
        end

        if (disp_fire) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = disp_op;
            dest_d[free_idx] = disp_dest_tag;
            qj_d[free_idx]   = disp_qj;
            vj_d[free_idx]   = disp_vj;
            qk_d[free_idx]   = disp_qk;
            vk_d[free_idx]   = disp_vk;
            if (disp_qj != '0) begin
                if (disp_qj == add_broad_tag) begin
                    qj_d[free_idx] = '0;
                    vj_d[free_idx] = add_broad_data;
                end else if (disp_qj == mul_broad_tag) begin
                    qj_d[free_idx] = '0;
                    vj_d[free_idx] = mul_broad_data;
                end
            end
            if (disp_qk != '0) begin
                if (disp_qk == add_broad_tag) begin
                    qk_d[free_idx] = '0;
                    vk_d[free_idx] = add_broad_data;
                end else if (disp_qk == mul_broad_tag) begin
                    qk_d[free_idx] = '0;
                    vk_d[free_idx] = mul_broad_data;
                end
            end
        end

        if (iss_fire) busy_d[sel_idx] = 1'b0;

        if (disp_fire && !iss_fire)      occ_d = occ_q + OCC_W'(1);
        else if (!disp_fire && iss_fire) occ_d = occ_q - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]   <= '0;
                dest_q[i] <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
            end
        end else begin
            busy_q <= busy_d;
            occ_q  <= occ_d;
            op_q   <= op_d;
            dest_q <= dest_d;
            qj_q   <= qj_d;
            qk_q   <= qk_d;
            vj_q   <= vj_d;
            vk_q   <= vk_d;
        end
    end
endmodule

// File: tb/tb_add_rs_snoop.sv
// Scoreboard bench for add_rs_snoop: expected issues are queued at dispatch and checked at issue.
module tb_add_rs_snoop;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        disp_valid = 1'b0;
    logic        disp_ready;
    logic [2:0]  disp_op = '0;
    logic [3:0]  disp_dest_tag = '0;
    logic [3:0]  disp_qj = '0;
    logic [3:0]  disp_qk = '0;
    logic [31:0] disp_vj = '0;
    logic [31:0] disp_vk = '0;
    logic [3:0]  add_broad_tag = '0;
    logic [31:0] add_broad_data = '0;
    logic [3:0]  mul_broad_tag = '0;
    logic [31:0] mul_broad_data = '0;
    logic        iss_valid;
    logic        iss_ready = 1'b0;
    logic [2:0]  iss_op;
    logic [3:0]  iss_tag;
    logic [31:0] iss_a;
    logic [31:0] iss_b;
    logic [2:0]  occupancy;

    typedef struct packed {
        logic [3:0]  tag;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    add_rs_snoop #(.DEPTH(4), .TAG_W(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_dest_tag(disp_dest_tag), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .add_broad_tag(add_broad_tag), .add_broad_data(add_broad_data),
        .mul_broad_tag(mul_broad_tag), .mul_broad_data(mul_broad_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_tag(iss_tag), .iss_a(iss_a), .iss_b(iss_b), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bcast();
        add_broad_tag  = '0;
        add_broad_data = '0;
        mul_broad_tag  = '0;
        mul_broad_data = '0;
    endtask

    task automatic disp(input logic [2:0] op, input logic [3:0] dest, input logic [3:0] qj,
                        input logic [31:0] vj, input logic [3:0] qk, input logic [31:0] vk);
        disp_valid    = 1'b1;
        disp_op       = op;
        disp_dest_tag = dest;
        disp_qj       = qj;
        disp_vj       = vj;
        disp_qk       = qk;
        disp_vk       = vk;
        step();
        disp_valid = 1'b0;
    endtask

    task automatic push(input logic [3:0] tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.tag = tag; e.op = op; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic issue_one();
        exp_t e;
        int   waited = 0;
        while (!iss_valid && waited < 20) begin
            step();
            waited++;
        end
        chk("iss_valid_wait", 32'(iss_valid), 32'd1);
        chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
        if (iss_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("iss_tag", 32'(iss_tag), 32'(e.tag));
            chk("iss_op", 32'(iss_op), 32'(e.op));
            chk("iss_a", iss_a, e.a);
            chk("iss_b", iss_b, e.b);
            iss_ready = 1'b1;
            step();
            iss_ready = 1'b0;
        end
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_iss_tag", 32'(iss_tag), 32'd0);
        chk("rst_iss_a", iss_a, 32'd0);

        // Ready-at-dispatch operation.
        push(4'd5, 3'd1, 32'd3, 32'd4);
        disp(3'd1, 4'd5, 4'd0, 32'd3, 4'd0, 32'd4);
        chk("r1_occ", 32'(occupancy), 32'd1);
        issue_one();
        chk("r1_occ_after", 32'(occupancy), 32'd0);
        chk("r1_iss_valid_after", 32'(iss_valid), 32'd0);

        // Pending qj resolved by the adder CDB.
        disp(3'd2, 4'd6, 4'd7, 32'd0, 4'd0, 32'd2);
        chk("r2_wait1", 32'(iss_valid), 32'd0);
        step();
        add_broad_tag = 4'd7; add_broad_data = 32'h10;
        push(4'd6, 3'd2, 32'h10, 32'd2);
        chk("r2_wait2", 32'(iss_valid), 32'd0);
        step();
        clear_bcast();
        chk("r2_ready", 32'(iss_valid), 32'd1);
        issue_one();

        // Capture at dispatch from the multiplier CDB.
        mul_broad_tag = 4'd9; mul_broad_data = 32'hAB;
        push(4'd3, 3'd4, 32'hAB, 32'h55);
        disp(3'd4, 4'd3, 4'd9, 32'd0, 4'd0, 32'h55);
        clear_bcast();
        chk("r3_ready", 32'(iss_valid), 32'd1);
        issue_one();

        // Same tag on both buses: adder data wins.
        disp(3'd3, 4'd8, 4'd0, 32'h1, 4'hA, 32'd0);
        add_broad_tag = 4'hA; add_broad_data = 32'h111;
        mul_broad_tag = 4'hA; mul_broad_data = 32'h222;
        push(4'd8, 3'd3, 32'h1, 32'h111);
        step();
        clear_bcast();
        issue_one();

        // Fill, reject overflow, drain.
        disp(3'd1, 4'd1, 4'hC, 32'd0, 4'd0, 32'h21);
        disp(3'd1, 4'd2, 4'hD, 32'd0, 4'd0, 32'h22);
        disp(3'd1, 4'd3, 4'hE, 32'd0, 4'd0, 32'h23);
        disp(3'd1, 4'd4, 4'hF, 32'd0, 4'd0, 32'h24);
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        disp(3'd5, 4'd9, 4'd0, 32'h9, 4'd0, 32'h9);
        chk("full_overflow_occ", 32'(occupancy), 32'd4);
        chk("full_overflow_iss", 32'(iss_valid), 32'd0);
        add_broad_tag = 4'hE; add_broad_data = 32'h77;
        push(4'd3, 3'd1, 32'h77, 32'h23);
        step();
        clear_bcast();
        issue_one();
        chk("full_freed_ready", 32'(disp_ready), 32'd1);
        chk("full_freed_occ", 32'(occupancy), 32'd3);
        add_broad_tag = 4'hC; add_broad_data = 32'h31;
        mul_broad_tag = 4'hD; mul_broad_data = 32'h32;
        step();
        clear_bcast();
        add_broad_tag = 4'hF; add_broad_data = 32'h33;
        step();
        clear_bcast();
        push(4'd1, 3'd1, 32'h31, 32'h21);
        push(4'd2, 3'd1, 32'h32, 32'h22);
        push(4'd4, 3'd1, 32'h33, 32'h24);
        issue_one();
        issue_one();
        issue_one();
        chk("drain_occ", 32'(occupancy), 32'd0);

        // Age versus index ordering: entry 1 dispatched before entry 0.
        push(4'd10, 3'd6, 32'h40, 32'h41);
        disp(3'd6, 4'd10, 4'd0, 32'h40, 4'd0, 32'h41);
        disp(3'd2, 4'd11, 4'd6, 32'd0, 4'd0, 32'h51);
        issue_one();
        disp(3'd3, 4'd12, 4'd5, 32'd0, 4'd0, 32'h61);
        add_broad_tag = 4'd5; add_broad_data = 32'h60;
        mul_broad_tag = 4'd6; mul_broad_data = 32'h50;
`ifdef RS_AGE_ORDER_EN
        push(4'd11, 3'd2, 32'h50, 32'h51);
        push(4'd12, 3'd3, 32'h60, 32'h61);
`else
        push(4'd12, 3'd3, 32'h60, 32'h61);
        push(4'd11, 3'd2, 32'h50, 32'h51);
`endif
        step();
        clear_bcast();
        chk("order_stall_tag", 32'(iss_tag), 32'(exp_q[0].tag));
        step();
        chk("order_stall_hold", 32'(iss_tag), 32'(exp_q[0].tag));
        issue_one();
        issue_one();

        // Reset while busy with dispatch/issue/broadcast all active.
        disp(3'd1, 4'd1, 4'd0, 32'h1, 4'd0, 32'h1);
        disp(3'd1, 4'd2, 4'd0, 32'h2, 4'd0, 32'h2);
        disp(3'd1, 4'd3, 4'd3, 32'h3, 4'd0, 32'h3);
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        chk("pre_rst_iss", 32'(iss_valid), 32'd1);
        reset = 1'b1;
        disp_valid = 1'b1; disp_dest_tag = 4'd7; disp_qj = 4'd0; disp_qk = 4'd0;
        iss_ready = 1'b1;
        add_broad_tag = 4'd3; add_broad_data = 32'hEE;
        step();
        reset = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
        clear_bcast();
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        chk("mid_rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("mid_rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("mid_rst_iss_tag", 32'(iss_tag), 32'd0);

        push(4'd13, 3'd7, 32'h5, 32'h6);
        disp(3'd7, 4'd13, 4'd0, 32'h5, 4'd0, 32'h6);
        issue_one();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("final_occ", 32'(occupancy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
